// File: rtl/systolic_drain.sv
// Snapshots the flat N*N result bus on a capture strobe and streams the elements
// out row-major over valid/ready, tagged with row/col indices and a last flag.
module systolic_drain #(
    parameter int W = 32,
    parameter int N = 3
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic                              i_capture,
    input  logic [W*N*N-1:0]                  i_C,
    output logic                              o_valid,
    input  logic                              i_ready,
    output logic [W-1:0]                      o_data,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] o_row,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] o_col,
    output logic                              o_last,
    output logic                              o_busy,
    output logic                              o_overrun,
    input  logic                              i_clr_overrun
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int NE = N * N;
    localparam int KW = (NE > 1) ? $clog2(NE) : 1;

    typedef enum logic {S_IDLE = 1'b0, S_STREAM = 1'b1} state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [W-1:0]    r_buf [NE];
    logic [W-1:0]    w_elem [NE];
    logic [KW-1:0]   r_k;
    logic [CW-1:0]   r_row;
    logic [CW-1:0]   r_col;
    logic            r_overrun;

    logic w_stream, w_xfer, w_at_last, w_final, w_accept, w_drop;

    genvar gi;
    generate
        for (gi = 0; gi < NE; gi++) begin : g_unpack
            assign w_elem[gi] = i_C[gi*W +: W];
        end
    endgenerate

    assign w_stream  = (r_state == S_STREAM);
    assign w_xfer    = w_stream && i_ready;
    assign w_at_last = (r_k == KW'(NE - 1));
    assign w_final   = w_xfer && w_at_last;
    // A capture coinciding with the final transfer reloads without a bubble.
    assign w_accept  = i_capture && (!w_stream || w_final);
    assign w_drop    = i_capture && w_stream && !w_final;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (i_capture) w_state_next = S_STREAM;
            S_STREAM: if (w_final && !i_capture) w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < NE; i++) r_buf[i] <= '0;
        end else if (w_accept) begin
            for (int i = 0; i < NE; i++) r_buf[i] <= w_elem[i];
        end
    end

    // Row/col run alongside k so no divider is needed.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_k   <= '0;
            r_row <= '0;
            r_col <= '0;
        end else if (w_accept || w_final) begin
            r_k   <= '0;
            r_row <= '0;
            r_col <= '0;
        end else if (w_xfer) begin
            r_k <= r_k + KW'(1);
            if (r_col == CW'(N - 1)) begin
                r_col <= '0;
                r_row <= r_row + CW'(1);
            end else begin
                r_col <= r_col + CW'(1);
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end else if (i_clr_overrun) begin
            r_overrun <= 1'b0;
        end
    end

    always_comb begin
        o_valid   = w_stream;
        o_busy    = w_stream;
        o_data    = '0;
        o_row     = r_row;
        o_col     = r_col;
        o_last    = w_stream && w_at_last;
        o_overrun = r_overrun;
        if (w_stream) o_data = r_buf[r_k];
    end
endmodule

// File: tb/tb_systolic_drain.sv
// Scoreboard bench for systolic_drain: expected beats are queued at capture time
// and compared against every valid beat observed on the output side.
module tb_systolic_drain;
    localparam int W  = 32;
    localparam int N  = 3;
    localparam int NE = N * N;
    localparam int CW = 2;

    typedef struct {
        logic [W-1:0] d;
        int           r;
        int           c;
        bit           l;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              capture = 1'b0;
    logic [W*NE-1:0]   c_bus = '0;
    logic              ready = 1'b0;
    logic              clr = 1'b0;
    logic              valid, last, busy, overrun;
    logic [W-1:0]      data;
    logic [CW-1:0]     row, col;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    logic [W-1:0] vals [NE];

    systolic_drain #(.W(W), .N(N)) dut (
        .i_clk(clk), .i_rst(rst), .i_capture(capture), .i_C(c_bus),
        .o_valid(valid), .i_ready(ready), .o_data(data), .o_row(row),
        .o_col(col), .o_last(last), .o_busy(busy), .o_overrun(overrun),
        .i_clr_overrun(clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Fill vals from a base (base+k) or randomly, drive the bus.
    task automatic load(input bit rnd, input logic [W-1:0] base);
        for (int k = 0; k < NE; k++) begin
            vals[k] = rnd ? W'($urandom) : base + W'(k);
            c_bus[k*W +: W] = vals[k];
        end
    endtask

    task automatic push_vals();
        for (int k = 0; k < NE; k++) begin
            exp_t e;
            e.d = vals[k];
            e.r = k / N;
            e.c = k % N;
            e.l = (k == NE - 1);
            q.push_back(e);
        end
    endtask

    // Called at posedge+1: pulse capture for one cycle, queuing the beats if accepted.
    task automatic do_capture(input bit accepted);
        capture = 1'b1;
        if (accepted) push_vals();
        @(posedge clk); #1;
        capture = 1'b0;
    endtask

    task automatic wait_drain(input string tag, input int max_cyc);
        int n = 0;
        while (q.size() > 0 && n < max_cyc) begin
            @(posedge clk); #1;
            n++;
        end
        if (q.size() > 0) begin
            chk({tag, "_timeout"}, 64'(q.size()), 64'd0);
            q.delete();
        end
    endtask

    task automatic wait_elem(input int r, input int c);
        int n = 0;
        while (!(valid && row == CW'(r) && col == CW'(c)) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) chk("wait_elem_timeout", 64'(n), 64'd0);
    endtask

    // Monitor: every valid beat must match the head of the scoreboard; pop on transfer.
    always @(negedge clk) begin
        if (!rst && valid) begin
            if (q.size() == 0) begin
                chk("spurious_valid", 64'(data), 64'hDEAD);
            end else begin
                chk("data", 64'(data), 64'(q[0].d));
                chk("row",  64'(row),  64'(q[0].r));
                chk("col",  64'(col),  64'(q[0].c));
                chk("last", 64'(last), 64'(q[0].l));
                chk("busy", 64'(busy), 64'd1);
                if (ready) void'(q.pop_front());
            end
        end
    end

    initial begin
        bit pat [11] = '{1,0,0,1,0,1,1,0,0,0,1};
        int n;
        bit sent;

        #12;
        chk("rst_valid",   64'(valid),   64'd0);
        chk("rst_busy",    64'(busy),    64'd0);
        chk("rst_overrun", 64'(overrun), 64'd0);
        chk("rst_data",    64'(data),    64'd0);
        chk("rst_last",    64'(last),    64'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // Basic drain with latency check.
        ready = 1'b1;
        load(0, 32'h100);
        do_capture(1);
        chk("latency_valid", 64'(valid), 64'd1);
        wait_drain("basic", 20);
        chk("basic_end_valid", 64'(valid), 64'd0);
        chk("basic_end_busy",  64'(busy),  64'd0);

        // Backpressure.
        load(0, 32'h100);
        do_capture(1);
        n = 0;
        while (q.size() > 0 && n < 200) begin
            ready = pat[n % 11];
            @(posedge clk); #1;
            n++;
        end
        chk("bp_remaining", 64'(q.size()), 64'd0);
        q.delete();
        ready = 1'b1;
        repeat (2) @(posedge clk); #1;

        // Overrun: dropped capture at element 4 leaves stream intact.
        load(0, 32'h100);
        do_capture(1);
        wait_elem(1, 1);
        load(0, 32'h200);
        do_capture(0);
        chk("ovr_set", 64'(overrun), 64'd1);
        wait_drain("ovr", 20);
        chk("ovr_hold", 64'(overrun), 64'd1);
        clr = 1'b1; @(posedge clk); #1; clr = 1'b0;
        chk("ovr_clr", 64'(overrun), 64'd0);
        // Clear and drop in the same cycle: set wins.
        load(0, 32'h300);
        do_capture(1);
        clr = 1'b1;
        do_capture(0);
        clr = 1'b0;
        chk("ovr_set_wins", 64'(overrun), 64'd1);
        wait_drain("ovr2", 20);
        clr = 1'b1; @(posedge clk); #1; clr = 1'b0;
        chk("ovr_clr2", 64'(overrun), 64'd0);

        // Back-to-back capture on the final transfer.
        load(0, 32'h100);
        do_capture(1);
        n = 0;
        sent = 0;
        while (q.size() > 0 && n < 40) begin
            chk("b2b_valid", 64'(valid), 64'd1);
            if (last && !sent) begin
                load(0, 32'h200);
                capture = 1'b1;
                push_vals();
                sent = 1;
            end
            @(posedge clk); #1;
            capture = 1'b0;
            n++;
        end
        chk("b2b_cycles",  64'(n),       64'd18);
        chk("b2b_overrun", 64'(overrun), 64'd0);
        chk("b2b_idle",    64'(valid),   64'd0);

        // Asynchronous reset mid-stream at element 5.
        load(0, 32'h500);
        do_capture(1);
        wait_elem(1, 2);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 64'(valid), 64'd0);
        chk("arst_busy",  64'(busy),  64'd0);
        chk("arst_data",  64'(data),  64'd0);
        chk("arst_row",   64'(row),   64'd0);
        chk("arst_col",   64'(col),   64'd0);
        q.delete();
        @(negedge clk); #3 rst = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            chk("arst_stay_idle", 64'(valid), 64'd0);
        end

        // Snapshot isolation with random data and a churning input bus.
        load(1, '0);
        do_capture(1);
        n = 0;
        while (q.size() > 0 && n < 30) begin
            for (int k = 0; k < NE; k++) c_bus[k*W +: W] = W'($urandom);
            @(posedge clk); #1;
            n++;
        end
        chk("snap_remaining", 64'(q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
